// File: rtl/data_mem_arbiter.sv
// Arbiter for the single-ported data memory: execute stage (port 0) has fixed
// priority, the DMA/debug loader (port 1) is protected from starvation by a wait counter.
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_mw,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        addr_err,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        WAIT_LIMIT = 4'(MAX_WAIT);

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_waitCnt;
  logic              w_force1;
  logic              w_selWe;
  logic              w_addrOver;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selWdata;

  // Port 1 overrides port 0 only once it has waited long enough; nothing is granted in reset.
  always_comb begin
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    w_force1 = p1_req && (r_waitCnt >= WAIT_LIMIT);
    if (!rst) begin
      if (w_force1)    p1_gnt = 1'b1;
      else if (p0_req) p0_gnt = 1'b1;
      else if (p1_req) p1_gnt = 1'b1;
    end
  end

  always_comb begin
    w_selAddr  = '0;
    w_selWdata = '0;
    w_selWe    = 1'b0;
    if (p0_gnt) begin
      w_selAddr  = p0_addr;
      w_selWdata = p0_wdata;
      w_selWe    = p0_we;
    end else if (p1_gnt) begin
      w_selAddr  = p1_addr;
      w_selWdata = p1_wdata;
      w_selWe    = p1_we;
    end
    w_addrOver = w_selAddr > MAX_ADDR;
    mem_addr   = w_addrOver ? MAX_ADDR : w_selAddr;
    mem_wdata  = w_selWdata;
    mem_mw     = w_selWe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      addr_err  <= 2'b00;
      r_waitCnt <= 4'd0;
    end else begin
      p0_rvalid <= p0_gnt && !p0_we;
      p1_rvalid <= p1_gnt && !p1_we;
      if (p0_gnt && !p0_we) p0_rdata <= mem_rdata;
      if (p1_gnt && !p1_we) p1_rdata <= mem_rdata;
      addr_err  <= {p1_gnt && w_addrOver, p0_gnt && w_addrOver};
      // Counts only consecutive denied cycles; saturates rather than wrapping.
      if (p1_req && !p1_gnt)
        r_waitCnt <= (r_waitCnt == 4'hF) ? r_waitCnt : r_waitCnt + 4'd1;
      else
        r_waitCnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = IDLE;
    if (p0_gnt)      w_nextState = G0;
    else if (p1_gnt) w_nextState = G1;
  end

  always_comb begin
    owner = r_state;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed vectors drive the ports, a
// monitor compares the registered responses against queued expectations.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_mw;
  logic [1:0]  addr_err, owner;

  logic [31:0] memArray [0:255];

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [31:0] rd;
    logic [1:0]  aerr;
    logic [1:0]  own;
  } exp_t;

  exp_t regQ[$];
  int   cyc     = 0;
  int   nChecks = 0;
  int   nPass   = 0;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mw(mem_mw),
    .mem_rdata(mem_rdata), .addr_err(addr_err), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural memory: asynchronous read, write at the rising edge.
  assign mem_rdata = memArray[mem_addr[7:0]];
  always @(posedge clk) if (mem_mw) memArray[mem_addr[7:0]] <= mem_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp)
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    else
      nPass++;
  endtask

  // One cycle of stimulus; combinational outputs checked here, registered ones queued.
  task automatic applyStimulus(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] wd0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] wd1,
    input logic [1:0] expGnt, input logic [31:0] expAddr, input logic [31:0] expRd,
    input bit lateRst);
    exp_t        e;
    logic        expMw;
    logic [31:0] expWd;
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = wd0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = wd1;
    expMw = expGnt[0] ? w0 : (expGnt[1] ? w1 : 1'b0);
    expWd = expGnt[0] ? wd0 : (expGnt[1] ? wd1 : 32'h0);
    e.due = cyc + 1;
    e.rd  = expRd;
    if (lateRst) begin
      e.rv = 2'b00; e.aerr = 2'b00; e.own = 2'b00;
    end else begin
      e.rv   = {expGnt[1] & ~w1, expGnt[0] & ~w0};
      e.aerr = {expGnt[1] && (a1 > 32'd255), expGnt[0] && (a0 > 32'd255)};
      e.own  = expGnt;
    end
    regQ.push_back(e);
    @(negedge clk);
    checkOutput("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, expGnt});
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_mw", {31'd0, mem_mw}, {31'd0, expMw});
    checkOutput("mem_wdata", mem_wdata, expWd);
    if (lateRst) begin
      #1;
      rst = 1'b1;
    end
  endtask

  // Requests are held high during reset to confirm nothing leaks through.
  task automatic resetDut(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd5; p0_wdata = 32'hFFFF_FFFF;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'd6; p1_wdata = 32'h0;
      if (i > 0) begin
        e.due = cyc + 1; e.rv = 2'b00; e.rd = 32'h0; e.aerr = 2'b00; e.own = 2'b00;
        regQ.push_back(e);
      end
      @(negedge clk);
      checkOutput("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      checkOutput("rst_mem_mw", {31'd0, mem_mw}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);
    end
  endtask

  // Monitor: compares registered outputs whenever a queued expectation falls due.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (regQ.size() > 0 && regQ[0].due <= cyc) begin
      e = regQ.pop_front();
      checkOutput("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e.rv[0]});
      checkOutput("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e.rv[1]});
      if (e.rv[0]) checkOutput("p0_rdata", p0_rdata, e.rd);
      if (e.rv[1]) checkOutput("p1_rdata", p1_rdata, e.rd);
      checkOutput("addr_err", {30'd0, addr_err}, {30'd0, e.aerr});
      checkOutput("owner", {30'd0, owner}, {30'd0, e.own});
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic [9:0] p1Turn;
    for (int i = 0; i < 256; i++) memArray[i] = i;
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;

    resetDut(3);

    $display("[TB] idle");
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);

    $display("[TB] single load");
    applyStimulus(1, 0, 32'd7, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01, 32'd7, 32'd7, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);

    $display("[TB] store then load");
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'd20, 32'hDEADBEEF, 2'b10, 32'd20, 32'd0, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd20, 32'd0, 2'b10, 32'd20, 32'hDEADBEEF, 0);

    $display("[TB] contention");
    p1Turn = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      if (p1Turn[i])
        applyStimulus(1, 0, 32'd3, 32'd0, 1, 0, 32'd9, 32'd0, 2'b10, 32'd9, 32'd9, 0);
      else
        applyStimulus(1, 0, 32'd3, 32'd0, 1, 0, 32'd9, 32'd0, 2'b01, 32'd3, 32'd3, 0);
    end

    $display("[TB] out of range");
    applyStimulus(1, 1, 32'd300, 32'h55, 0, 0, 32'd0, 32'd0, 2'b01, 32'd255, 32'd0, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);
    applyStimulus(1, 0, 32'd255, 32'd0, 0, 0, 32'd0, 32'd0, 2'b01, 32'd255, 32'h55, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd1000, 32'd0, 2'b10, 32'd255, 32'h55, 0);

    $display("[TB] reset mid-read");
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd9, 32'd0, 2'b10, 32'd9, 32'd9, 1);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);

    $display("[TB] contention after reset");
    for (int i = 0; i < 5; i++) begin
      if (p1Turn[i])
        applyStimulus(1, 0, 32'd3, 32'd0, 1, 0, 32'd9, 32'd0, 2'b10, 32'd9, 32'd9, 0);
      else
        applyStimulus(1, 0, 32'd3, 32'd0, 1, 0, 32'd9, 32'd0, 2'b01, 32'd3, 32'd3, 0);
    end

    $display("[TB] back-to-back port 1");
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd1, 32'd0, 2'b10, 32'd1, 32'd1, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd2, 32'd0, 2'b10, 32'd2, 32'd2, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0, 2'b10, 32'd3, 32'd3, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 2'b00, 32'd0, 32'd0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", regQ.size(), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Arbitrates the single-ported 256 x 32 data memory between two requesters: port 0 (execute stage, load/store) and port 1 (DMA / debug loader).
- Issues at most one memory access per cycle, drives the memory's address, write-data and MW lines, and returns registered read data.
- Port 0 has fixed priority. A wait counter guarantees port 1 is not starved.
- Sits between the execute stage and the data memory.

Parameters:
- ADDR_W, 32, width of requester and memory address buses
- DATA_W, 32, data width
- DEPTH, 256, number of memory words; the highest legal address is DEPTH-1
- MAX_WAIT, 4, number of consecutive cycles port 1 may be denied while requesting before it is forced to win (range 1-15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 access request; held until p0_gnt
- p0_we  in  1  port 0 write enable (1 = store, 0 = load)
- p0_addr  in  ADDR_W  port 0 word address
- p0_wdata  in  DATA_W  port 0 store data
- p0_gnt  out  1  port 0 granted this cycle (combinational)
- p0_rvalid  out  1  port 0 read data valid (registered)
- p0_rdata  out  DATA_W  port 0 read data (registered)
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Data_in
- mem_mw  out  1  to memory MW
- mem_rdata  in  DATA_W  from memory Data_out (asynchronous read)
- addr_err  out  2  registered one-cycle pulse per port: the granted address was above DEPTH-1
- owner  out  2  registered arbiter state: 00 IDLE, 01 G0, 10 G1

Behaviour:
- Reset values: rst high at a posedge clears the following to 0:
  - p0_rvalid, p1_rvalid, p0_rdata, p1_rdata
  - addr_err, wait_cnt
  - owner, which goes to IDLE
- Outputs while rst is high or no request is granted: gnt signals, mem_mw, mem_addr and mem_wdata are all 0.
- Grant rule (combinational, same cycle as req):
  - force1 = p1_req and (wait_cnt >= MAX_WAIT).
  - If force1: p1_gnt = 1.
  - Else if p0_req: p0_gnt = 1.
  - Else if p1_req: p1_gnt = 1.
  - p0_gnt and p1_gnt are never both 1.
- Memory drive: mem_addr, mem_wdata and we come from the granted port. mem_mw = granted port's we.
- Address clamp: a granted address > DEPTH-1 is driven as DEPTH-1, and addr_err[port] pulses high the following cycle. There is no other side effect; the access proceeds.
- Read path (1-cycle latency):
  - On a granted load, mem_rdata is captured into that port's rdata at the posedge.
  - That port's rvalid is high for exactly the next cycle.
  - rdata holds its value until the next load for that port.
  - A granted store produces no rvalid.
- Wait counter:
  - Increments (saturating at 15) each cycle p1_req = 1 and p1_gnt = 0.
  - Clears to 0 on p1_gnt, or when p1_req = 0.
- State machine (owner): next state is G0 if p0_gnt, G1 if p1_gnt, IDLE otherwise. Transitions are unrestricted; state is used for observability and wait accounting only.
- Back-to-back requests: one access per cycle. A port holding req high across consecutive grants gets consecutive accesses. Its rvalid can be high every cycle.
- Simultaneous requests:
  - Port 0 wins until port 1 has been denied MAX_WAIT cycles.
  - Port 1 then wins exactly one cycle, because wait_cnt clears.
  - Port 0 is stalled (p0_gnt = 0) for that cycle.
- Ordering: a store and a following load to the same address from different ports in consecutive cycles observe the store, because memory writes at the posedge.
- Reset mid-operation: any rvalid due the next cycle is suppressed, pending requests are not remembered, and requesters must reissue after rst falls.

Test Plan:
- Single load: memory preloaded with DATA[i] = i. p0 loads addr 7 → p0_gnt in the same cycle; next cycle p0_rvalid = 1 with p0_rdata = 7; rvalid = 0 the cycle after.
- Store then load: p1 stores 0xDEADBEEF at addr 20 (mem_mw = 1); next cycle p1 loads addr 20 → following cycle p1_rdata = 0xDEADBEEF, p1_rvalid = 1.
- Contention with MAX_WAIT = 4: p0_req and p1_req both held high, both loads.
  - Required grant sequence: p0, p0, p0, p0, p1, p0, p0, p0, p0, p1.
  - Each cycle exactly one gnt; owner tracks G0/G1 accordingly.
- Out of range: p0 stores 0x55 at addr 300 → mem_addr = 255; addr_err = 01 the next cycle. A later load of addr 255 returns 0x55.
- Reset mid-read: p1 load granted at cycle N, rst = 1 at the posedge ending cycle N → p1_rvalid stays 0; wait_cnt, owner and addr_err are 0 after reset.
- Idle: no requests for 10 cycles → mem_mw = 0, both gnt = 0, owner = IDLE, wait_cnt = 0 throughout.
